// File: rtl/bp_fe_miss_ctrl.sv
// bp_fe_miss_ctrl: sequences one outstanding I-cache miss onto the LCE cache_req
// port. It sends the request, emits the way metadata one cycle after the
// handshake, then waits for the fill. A pc_gen poison either cancels an unissued
// request or drains an issued one. It also provides a done pulse, a sticky
// timeout flag and saturating perf counters. Every output is driven by a register.
module bp_fe_miss_ctrl #(
  parameter int req_width_p      = 64,
  parameter int meta_width_p     = 4,
  parameter int timeout_cycles_p = 1024,
  parameter int ctr_width_p      = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    miss_v_i,
  input  logic [req_width_p-1:0]  miss_req_i,
  output logic                    miss_ready_o,
  input  logic                    meta_v_i,
  input  logic [meta_width_p-1:0] meta_i,
  input  logic                    poison_i,
  output logic [req_width_p-1:0]  cache_req_o,
  output logic                    cache_req_v_o,
  input  logic                    cache_req_ready_i,
  output logic [meta_width_p-1:0] cache_req_metadata_o,
  output logic                    cache_req_metadata_v_o,
  input  logic                    cache_req_complete_i,
  output logic                    busy_o,
  output logic                    miss_done_o,
  output logic                    timeout_o,
  output logic [ctr_width_p-1:0]  miss_count_o,
  output logic [ctr_width_p-1:0]  stall_count_o
);

  localparam int TW = (timeout_cycles_p > 1) ? $clog2(timeout_cycles_p) : 1;
  localparam logic [TW-1:0]          TMAX = TW'(timeout_cycles_p - 1);
  localparam logic [ctr_width_p-1:0] CMAX = '1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DRAIN} state_e;

  state_e                  state_q;
  logic                    ready_q, busy_q, req_v_q, meta_v_q, done_q, timeout_q;
  logic                    accept_q;
  logic [req_width_p-1:0]  req_q;
  logic [meta_width_p-1:0] meta_q;
  logic [TW-1:0]           timer_q;
  logic [ctr_width_p-1:0]  miss_cnt_q, stall_cnt_q;

  // Miss FSM: state, registered outputs, metadata capture, timer and counters.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      req_v_q     <= 1'b0;
      meta_v_q    <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      accept_q    <= 1'b0;
      req_q       <= '0;
      meta_q      <= '0;
      timer_q     <= '0;
      miss_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      done_q   <= 1'b0;
      meta_v_q <= 1'b0;
      accept_q <= 1'b0;
      if (busy_q && (stall_cnt_q != CMAX)) stall_cnt_q <= stall_cnt_q + 1'b1;
      // The metadata only arrives in the cycle right after the miss is accepted.
      if (accept_q && meta_v_i) meta_q <= meta_i;
      case (state_q)
        IDLE: begin
          if (miss_v_i && !poison_i) begin
            req_q    <= miss_req_i;
            accept_q <= 1'b1;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            req_v_q  <= 1'b1;
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (cache_req_ready_i) begin
            if (miss_cnt_q != CMAX) miss_cnt_q <= miss_cnt_q + 1'b1;
            req_v_q  <= 1'b0;
            meta_v_q <= 1'b1;
            timer_q  <= '0;
            state_q  <= poison_i ? DRAIN : WAIT;
          end else if (poison_i) begin
            req_v_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        WAIT, DRAIN: begin
          if (timer_q == TMAX) timeout_q <= 1'b1;
          if (timer_q != TMAX) timer_q <= timer_q + 1'b1;
          if (cache_req_complete_i) begin
            done_q  <= (state_q == WAIT);
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else if (poison_i && (state_q == WAIT)) begin
            timer_q <= '0;
            state_q <= DRAIN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miss_ready_o           = ready_q;
  assign cache_req_o            = req_q;
  assign cache_req_v_o          = req_v_q;
  assign cache_req_metadata_o   = meta_q;
  assign cache_req_metadata_v_o = meta_v_q;
  assign busy_o                 = busy_q;
  assign miss_done_o            = done_q;
  assign timeout_o              = timeout_q;
  assign miss_count_o           = miss_cnt_q;
  assign stall_count_o          = stall_cnt_q;

endmodule
